// File: rtl/uart_tx_periph_if.sv
// Bus interface for uart_tx_periph: MEM-stage word access signals.
interface uart_tx_periph_if;
    logic [31:0] addr;
    logic        Mem_rd;
    logic        Mem_wr;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    // Pipeline / bus decoder side.
    modport master (
        output addr,
        output Mem_rd,
        output Mem_wr,
        output Write_data,
        input  Read_data
    );

    // Peripheral side.
    modport slave (
        input  addr,
        input  Mem_rd,
        input  Mem_wr,
        input  Write_data,
        output Read_data
    );
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, programmable baud divisor and
// drain interrupt. Register window: TXDATA, STATUS, CTRL, BAUDDIV.
// Optional macro UART_TX_PARITY_EN adds a parity bit (CTRL bit2: 0 even, 1 odd).
module uart_tx_periph #(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0010,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_periph_if.slave bus,
    output logic            tx,
    output logic            irq
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned CtrlW = 3;
`else
    localparam int unsigned CtrlW = 2;
`endif

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // Register file and FIFO state
    logic [CtrlW-1:0] ctrl_q;
    logic [15:0]      div_q;
    logic             overrun_q;
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;

    // Transmit FSM state
    state_e           state_q;
    logic             tx_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_cnt_q;
    logic [15:0]      baud_cnt_q;
    logic [15:0]      bit_div_q;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
`endif

    logic        sel, wr_txdata, wr_status, wr_ctrl, wr_div;
    logic [1:0]  idx;
    logic        full, empty, push, pop, bit_end, busy;
    logic [15:0] div_eff;
    logic [7:0]  head;
    logic [31:0] status;
    logic [31:0] rdata;
    logic        unused_bits;

    assign sel       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign idx       = bus.addr[3:2];
    assign wr_txdata = sel && bus.Mem_wr && (idx == 2'd0);
    assign wr_status = sel && bus.Mem_wr && (idx == 2'd1);
    assign wr_ctrl   = sel && bus.Mem_wr && (idx == 2'd2);
    assign wr_div    = sel && bus.Mem_wr && (idx == 2'd3);

    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign head    = fifo_q[rd_ptr_q];
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bit_end = (baud_cnt_q == bit_div_q - 16'd1);
    assign busy    = (state_q != StIdle);
    // Pops happen when leaving IDLE or at the end of a stop bit (back-to-back frames).
    assign pop     = ctrl_q[0] && !empty &&
                     ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
    assign push    = wr_txdata && (!full || pop);

    assign tx  = tx_q;
    assign irq = ctrl_q[1] && empty && (state_q == StIdle);

    assign unused_bits = ^{bus.addr[1:0], bus.Write_data[31:16]};

    assign status = {17'd0, 7'(count_q), 4'd0, overrun_q, empty, full, busy};

    // Combinational read mux; zero when not addressed.
    always_comb begin
        rdata = '0;
        if (sel && bus.Mem_rd) begin
            case (idx)
                2'd1:    rdata = status;
                2'd2:    rdata = {{(32 - CtrlW){1'b0}}, ctrl_q};
                2'd3:    rdata = {16'd0, div_q};
                default: rdata = '0;
            endcase
        end
    end
    assign bus.Read_data = rdata;

    // FIFO occupancy next-state.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.Write_data[7:0];
        end
    end

    // FIFO pointers, count and software-visible registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ctrl_q    <= '0;
            div_q     <= DEFAULT_DIV;
            overrun_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_ctrl) ctrl_q <= bus.Write_data[CtrlW-1:0];
            if (wr_div)  div_q  <= bus.Write_data[15:0];
            // A new overrun wins over a same-cycle clear.
            if (wr_txdata && full && !pop) begin
                overrun_q <= 1'b1;
            end else if (wr_status && bus.Write_data[3]) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Transmit FSM: each bit lasts bit_div_q cycles, latched at every bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            bit_div_q  <= 16'd1;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            if (state_q != StIdle) begin
                baud_cnt_q <= bit_end ? 16'd0 : baud_cnt_q + 16'd1;
            end
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q    <= StStart;
                        tx_q       <= 1'b0;
                        shift_q    <= head;
                        baud_cnt_q <= '0;
                        bit_div_q  <= div_eff;
`ifdef UART_TX_PARITY_EN
                        par_q      <= (^head) ^ ctrl_q[2];
`endif
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q   <= StData;
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        bit_div_q <= div_eff;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        bit_div_q <= div_eff;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= StParity;
                            tx_q    <= par_q;
`else
                            state_q <= StStop;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        state_q   <= StStop;
                        tx_q      <= 1'b1;
                        bit_div_q <= div_eff;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        bit_div_q <= div_eff;
                        if (pop) begin
                            state_q <= StStart;
                            tx_q    <= 1'b0;
                            shift_q <= head;
`ifdef UART_TX_PARITY_EN
                            par_q   <= (^head) ^ ctrl_q[2];
`endif
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: reads and serial frames are queued as expectations
// and checked by independent monitors.
module tb_uart_tx_periph;
    localparam logic [31:0] Base  = 32'h4000_0010;
    localparam logic [31:0] ATx   = Base;
    localparam logic [31:0] ASt   = Base + 32'd4;
    localparam logic [31:0] ACtrl = Base + 32'd8;
    localparam logic [31:0] ADiv  = Base + 32'd12;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] Ctrl7Exp = 32'd7;
`else
    localparam logic [31:0] Ctrl7Exp = 32'd3;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tx, irq;
    int   checks = 0;
    int   errors = 0;
    int   frames_done = 0;

    uart_tx_periph_if bus ();

    uart_tx_periph #(
        .BASE_ADDR  (Base),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    // bits[i] is the i-th level on the line (start first).
    typedef struct {
        logic [10:0] bits;
        int          nbits;
        int          div;
        bit          b2b;
        string       name;
    } frame_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_t;

    frame_t fq[$];
    rd_t    rq[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr       = a;
        bus.Write_data = d;
        bus.Mem_wr     = 1'b1;
        @(posedge clk);
        #1;
        bus.Mem_wr     = 1'b0;
        bus.addr       = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string n);
        rd_t r;
        r.exp  = e;
        r.name = n;
        rq.push_back(r);
        bus.addr   = a;
        bus.Mem_rd = 1'b1;
        @(posedge clk);
        #1;
        bus.Mem_rd = 1'b0;
        bus.addr   = '0;
    endtask

    task automatic expect_frame(input logic [10:0] bits, input int nbits, input int div,
                                input bit b2b, input string n);
        frame_t f;
        f.bits  = bits;
        f.nbits = nbits;
        f.div   = div;
        f.b2b   = b2b;
        f.name  = n;
        fq.push_back(f);
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_done < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("frames_done", frames_done, target);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Read monitor: every strobed read is compared against the oldest expectation.
    always @(negedge clk) begin
        rd_t r;
        if (bus.Mem_rd === 1'b1) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%08h expected none", bus.Read_data);
            end else begin
                r = rq.pop_front();
                chk(r.name, bus.Read_data, r.exp);
            end
        end
    end

    // Line monitor: finds each start bit and checks every cycle of every bit.
    initial begin : frame_mon
        frame_t      f;
        int          n;
        logic [31:0] act;
        forever begin
            wait (fq.size() != 0);
            f = fq.pop_front();
            @(negedge clk);
            if (!f.b2b) begin
                n = 0;
                while (tx !== 1'b0 && n < 4000) begin
                    @(negedge clk);
                    n++;
                end
            end
            chk({f.name, "_start"}, tx, 32'd0);
            for (int i = 0; i < f.nbits; i++) begin
                act = {31'd0, f.bits[i]};
                for (int c = 0; c < f.div; c++) begin
                    if (i != 0 || c != 0) @(negedge clk);
                    if (tx !== f.bits[i]) act = {31'd0, tx};
                end
                chk($sformatf("%s_bit%0d", f.name, i), act, {31'd0, f.bits[i]});
            end
            frames_done++;
        end
    end

    initial begin
        reset          = 1'b1;
        bus.addr       = '0;
        bus.Mem_rd     = 1'b0;
        bus.Mem_wr     = 1'b0;
        bus.Write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 32'd1);
        chk("rst_irq", irq, 32'd0);
        reset = 1'b0;
        bus_rd(ASt, 32'h4, "rst_status");
        bus_rd(ACtrl, 32'h0, "rst_ctrl");
        bus_rd(ADiv, 32'd868, "rst_div");
        bus_rd(ATx, 32'h0, "txdata_rd");
        bus_rd(32'h4000_0020, 32'h0, "unsel_rd");

        // Single 0xA5 frame at 4 cycles/bit.
        bus_wr(ADiv, 32'd4);
        bus_wr(ACtrl, 32'd1);
        expect_frame(11'b01101001010, 10, 4, 1'b0, "a5");
        bus_wr(ATx, 32'hA5);
        bus_rd(ASt, 32'h100, "after_push");
        bus_rd(ASt, 32'h5, "busy");
        wait_frames(1);
        bus_rd(ASt, 32'h4, "idle_after_a5");

        // Divisor 0 behaves as 1 cycle/bit.
        bus_wr(ADiv, 32'd0);
        expect_frame(11'b01101001010, 10, 1, 1'b0, "div0");
        bus_wr(ATx, 32'hA5);
        wait_frames(2);

        // Overflow the FIFO with transmission disabled.
        bus_wr(ACtrl, 32'd0);
        for (int i = 0; i < 9; i++) bus_wr(ATx, 32'(i));
        bus_rd(ASt, 32'h80A, "full_overrun");
        bus_wr(ASt, 32'h8);
        bus_rd(ASt, 32'h802, "overrun_clr");

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus_rd(ASt, 32'h4, "flush_status");

        bus_wr(ACtrl, 32'd7);
        bus_rd(ACtrl, Ctrl7Exp, "ctrl_bits");
        chk("irq_idle", irq, 32'd1);
        bus_wr(ACtrl, 32'd0);
        chk("irq_off", irq, 32'd0);

        // Two queued bytes leave back-to-back.
        bus_wr(ADiv, 32'd2);
        expect_frame(11'b01010101010, 10, 2, 1'b0, "b55");
        expect_frame(11'b01000011110, 10, 2, 1'b1, "b0f");
        bus_wr(ATx, 32'h55);
        bus_wr(ATx, 32'h0F);
        bus_wr(ACtrl, 32'd1);
        wait_frames(4);
        bus_rd(ASt, 32'h4, "idle_after_b2b");

        // Interrupt stays low during a frame and rises when drained and idle.
        expect_frame(11'b01001111000, 10, 2, 1'b0, "b3c");
        bus_wr(ATx, 32'h3C);
        bus_wr(ACtrl, 32'd3);
        chk("irq_frame_start", irq, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("irq_mid", irq, 32'd0);
        wait_frames(5);
        chk("irq_done", irq, 32'd1);
        bus_wr(ACtrl, 32'd1);
        chk("irq_dis", irq, 32'd0);

        // Reset in the middle of the first data bit of 0x00 with a second byte queued.
        bus_wr(ADiv, 32'd8);
        bus_wr(ATx, 32'h00);
        bus_wr(ATx, 32'h00);
        repeat (12) @(posedge clk);
        #1;
        chk("pre_rst_tx", tx, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_tx", tx, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_rd(ASt, 32'h4, "post_rst_status");
        bus_rd(ADiv, 32'd868, "post_rst_div");

`ifdef UART_TX_PARITY_EN
        // Odd parity on 0x03 gives parity bit 1.
        bus_wr(ADiv, 32'd2);
        bus_wr(ACtrl, 32'd5);
        expect_frame(11'b11000000110, 11, 2, 1'b0, "par03");
        bus_wr(ATx, 32'h03);
        wait_frames(6);
`endif

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
